// File: rtl/dds_pkg.sv
// Shared constants, quadrant type and quarter-sine table generator
// for the DDS phase/waveform generator.
package dds_pkg;

    localparam int ACC_W = 32;
    localparam int PH_W  = 14;

    localparam logic [13:0] MID_CODE  = 14'd8192;
    localparam logic [13:0] FULL_CODE = 14'd16383;

    // pi scaled by 2^30
    localparam longint unsigned PI_Q30 = 64'd3373259426;

    typedef enum logic [1:0] {
        Q_RISE     = 2'd0,
        Q_FALL     = 2'd1,
        Q_NEG_FALL = 2'd2,
        Q_NEG_RISE = 2'd3
    } quad_t;

    // round((2^(aw+1)-1) * sin((i+0.5)*pi/2^(aw+1))), Q30 Taylor series
    function automatic int qsin(input int i, input int aw);
        longint unsigned x;
        longint unsigned x2;
        longint unsigned term;
        longint unsigned acc_p;
        longint unsigned acc_n;
        longint unsigned amp;
        x     = (PI_Q30 * 64'(2 * i + 1)) >> (aw + 2);
        x2    = (x * x) >> 30;
        term  = x;
        acc_p = x;
        acc_n = 64'd0;
        for (int k = 1; k <= 8; k++) begin
            term = (term * x2) >> 30;
            term = term / 64'(2 * k * (2 * k + 1));
            if (k % 2 == 1) acc_n = acc_n + term;
            else            acc_p = acc_p + term;
        end
        amp = (64'd1 << (aw + 1)) - 64'd1;
        return int'(((acc_p - acc_n) * amp + (64'd1 << 29)) >> 30);
    endfunction

endpackage

// File: rtl/sine_qrom.sv
// Quarter-wave sine magnitude table, one-cycle synchronous read.
// Contents are computed at elaboration from dds_pkg::qsin.
module sine_qrom
    import dds_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 13
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0] w_rom [2**AW];

    for (genvar g = 0; g < 2**AW; g++) begin : g_rom
        localparam logic [DW-1:0] VAL = DW'(qsin(g, AW));
        assign w_rom[g] = VAL;
    end

    always_ff @(posedge clk) begin
        o_data <= w_rom[i_addr];
    end

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator with sine/triangle/saw/square outputs.
// Define SWEEP_EN to add the linear frequency sweep (sweep_step, f_stop).
module dds_phase_gen #(
    parameter int ACC_W = dds_pkg::ACC_W,
    parameter int PH_W  = dds_pkg::PH_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_load,
    input  logic [ACC_W-1:0] f_word,
    input  logic [PH_W-1:0]  p_word,
    input  logic [PH_W-1:0]  duty,
`ifdef SWEEP_EN
    input  logic [ACC_W-1:0] sweep_step,
    input  logic [ACC_W-1:0] f_stop,
`endif
    output logic             cfg_busy,
    output logic [PH_W-1:0]  dac_data0,
    output logic [PH_W-1:0]  dac_data1,
    output logic [PH_W-1:0]  dac_data2,
    output logic [PH_W-1:0]  dac_data3,
    output logic             sync
);
    import dds_pkg::*;

    logic [ACC_W-1:0] r_acc;
    logic             r_wrap0;
    logic [ACC_W-1:0] r_f_sh;
    logic [ACC_W-1:0] r_f_act;
    logic [PH_W-1:0]  r_p_sh;
    logic [PH_W-1:0]  r_p_act;
    logic [PH_W-1:0]  r_d_sh;
    logic [PH_W-1:0]  r_d_act;
    logic             r_busy;

    logic [ACC_W:0]   w_sum;
    logic             w_wrap;
    logic             w_xfer;
    logic [ACC_W-1:0] w_f_nxt;

    assign w_sum    = {1'b0, r_acc} + {1'b0, r_f_act};
    assign w_wrap   = run & w_sum[ACC_W];
    // Stopped accumulator never wraps, so apply on the next cycle
    assign w_xfer   = r_busy & (w_wrap | ~run);
    assign cfg_busy = r_busy;

`ifdef SWEEP_EN
    logic [ACC_W-1:0] r_step_sh;
    logic [ACC_W-1:0] r_step_act;
    logic [ACC_W-1:0] r_stop_sh;
    logic [ACC_W-1:0] r_stop_act;
    logic [ACC_W:0]   w_sweep;

    assign w_sweep = {1'b0, r_f_act} + {1'b0, r_step_act};

    always_comb begin
        w_f_nxt = r_f_act;
        if (w_xfer) begin
            w_f_nxt = r_f_sh;
        end else if (w_wrap) begin
            // Past the stop word: restart from the shadow start word
            if (w_sweep > {1'b0, r_stop_act}) w_f_nxt = r_f_sh;
            else                              w_f_nxt = w_sweep[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_sh  <= '0;
            r_step_act <= '0;
            r_stop_sh  <= '0;
            r_stop_act <= '0;
        end else begin
            if (cfg_load) begin
                r_step_sh <= sweep_step;
                r_stop_sh <= f_stop;
            end
            if (w_xfer) begin
                r_step_act <= r_step_sh;
                r_stop_act <= r_stop_sh;
            end
        end
    end
`else
    assign w_f_nxt = w_xfer ? r_f_sh : r_f_act;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_sh  <= '0;
            r_p_sh  <= '0;
            r_d_sh  <= '0;
            r_f_act <= '0;
            r_p_act <= '0;
            r_d_act <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (cfg_load) begin
                r_f_sh <= f_word;
                r_p_sh <= p_word;
                r_d_sh <= duty;
            end
            if (w_xfer) begin
                r_p_act <= r_p_sh;
                r_d_act <= r_d_sh;
            end
            r_f_act <= w_f_nxt;
            r_busy  <= cfg_load | (r_busy & ~w_xfer);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_wrap0 <= 1'b0;
        end else begin
            if (run) r_acc <= w_sum[ACC_W-1:0];
            r_wrap0 <= w_wrap;
        end
    end

    logic [PH_W-1:0] w_ph;
    quad_t           w_q;
    logic [PH_W-3:0] w_a;
    logic [PH_W-3:0] w_addr;

    assign w_ph = r_acc[ACC_W-1 -: PH_W] + r_p_act;
    assign w_q  = quad_t'(w_ph[PH_W-1 -: 2]);
    assign w_a  = w_ph[PH_W-3:0];

    always_comb begin
        w_addr = w_a;
        unique case (w_q)
            Q_RISE, Q_NEG_FALL: w_addr = w_a;
            Q_FALL, Q_NEG_RISE: w_addr = ~w_a;
        endcase
    end

    logic [PH_W-1:0] r_s1_ph;
    quad_t           r_s1_q;
    logic [PH_W-3:0] r_s1_addr;
    logic            r_s1_sq;
    logic            r_s1_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_ph   <= '0;
            r_s1_q    <= Q_RISE;
            r_s1_addr <= '0;
            r_s1_sq   <= 1'b0;
            r_s1_wrap <= 1'b0;
        end else begin
            r_s1_ph   <= w_ph;
            r_s1_q    <= w_q;
            r_s1_addr <= w_addr;
            r_s1_sq   <= (w_ph < r_d_act);
            r_s1_wrap <= r_wrap0;
        end
    end

    logic [PH_W-2:0] w_mag;

    sine_qrom #(
        .AW(PH_W - 2),
        .DW(PH_W - 1)
    ) u_rom (
        .clk   (clk),
        .i_addr(r_s1_addr),
        .o_data(w_mag)
    );

    logic [PH_W-1:0] w_tri2;
    logic [PH_W-1:0] r_s2_saw;
    logic [PH_W-1:0] r_s2_tri;
    logic [PH_W-1:0] r_s2_sq;
    quad_t           r_s2_q;
    logic            r_s2_wrap;

    assign w_tri2 = {r_s1_ph[PH_W-2:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_saw  <= '0;
            r_s2_tri  <= '0;
            r_s2_sq   <= '0;
            r_s2_q    <= Q_RISE;
            r_s2_wrap <= 1'b0;
        end else begin
            r_s2_saw  <= r_s1_ph;
            r_s2_tri  <= r_s1_ph[PH_W-1] ? FULL_CODE - w_tri2 : w_tri2;
            r_s2_sq   <= r_s1_sq ? FULL_CODE : '0;
            r_s2_q    <= r_s1_q;
            r_s2_wrap <= r_s1_wrap;
        end
    end

    logic w_neg;

    assign w_neg = (r_s2_q == Q_NEG_FALL) || (r_s2_q == Q_NEG_RISE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_data0 <= MID_CODE;
            dac_data1 <= '0;
            dac_data2 <= '0;
            dac_data3 <= '0;
            sync      <= 1'b0;
        end else begin
            dac_data0 <= w_neg ? MID_CODE - {1'b0, w_mag}
                               : MID_CODE + {1'b0, w_mag};
            dac_data1 <= r_s2_tri;
            dac_data2 <= r_s2_saw;
            dac_data3 <= r_s2_sq;
            sync      <= r_s2_wrap;
        end
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed self-checking bench for dds_phase_gen; build with
// SWEEP_EN defined to also exercise the frequency sweep.
module tb_dds_phase_gen;

    logic        clk;
    logic        rst;
    logic        run;
    logic        cfg_load;
    logic [31:0] f_word;
    logic [13:0] p_word;
    logic [13:0] duty;
`ifdef SWEEP_EN
    logic [31:0] sweep_step;
    logic [31:0] f_stop;
`endif
    logic        cfg_busy;
    logic [13:0] dac_data0;
    logic [13:0] dac_data1;
    logic [13:0] dac_data2;
    logic [13:0] dac_data3;
    logic        sync;

    int tests;
    int fails;

    dds_phase_gen dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_load  (cfg_load),
        .f_word    (f_word),
        .p_word    (p_word),
        .duty      (duty),
`ifdef SWEEP_EN
        .sweep_step(sweep_step),
        .f_stop    (f_stop),
`endif
        .cfg_busy  (cfg_busy),
        .dac_data0 (dac_data0),
        .dac_data1 (dac_data1),
        .dac_data2 (dac_data2),
        .dac_data3 (dac_data3),
        .sync      (sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed sine codes at the phases the benches visit
    function automatic int sine_ref(input int ph);
        case (ph)
            0:       return 8194;
            2048:    return 13985;
            4096:    return 16383;
            6144:    return 13983;
            8192:    return 8190;
            10240:   return 2399;
            12288:   return 1;
            14336:   return 2401;
            default: return -1;
        endcase
    endfunction

    task automatic check_wave(input int ph, input int d, input logic sy);
        int tri_e;
        int sin_e;
        tri_e = (ph >= 8192) ? 16383 - 2 * (ph - 8192) : 2 * ph;
        chk("saw", dac_data2, ph);
        chk("tri", dac_data1, tri_e);
        chk("square", dac_data3, (ph < d) ? 16383 : 0);
        chk("sync", sync, sy);
        sin_e = sine_ref(ph);
        if (sin_e >= 0) chk("sine", dac_data0, sin_e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sine"}, dac_data0, 8192);
        chk({tag, "_tri"}, dac_data1, 0);
        chk({tag, "_saw"}, dac_data2, 0);
        chk({tag, "_sq"}, dac_data3, 0);
        chk({tag, "_sync"}, sync, 0);
        chk({tag, "_busy"}, cfg_busy, 0);
    endtask

    // Async reset mid-run, then load config with run=0 and start running
    task automatic restart(input logic [31:0] f, input logic [13:0] p,
                           input logic [13:0] d);
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        run      = 1'b0;
        cfg_load = 1'b1;
        f_word   = f;
        p_word   = p;
        duty     = d;
        step();
        cfg_load = 1'b0;
        chk("load_busy", cfg_busy, 1);
        step();
        chk("xfer_busy", cfg_busy, 0);
        run = 1'b1;
    endtask

    // Start at f=2^28; optionally reload f once or twice mid-period
    task automatic seq(input logic [13:0] p, input logic [13:0] d,
                       input int nload, input logic [31:0] fa,
                       input logic [31:0] fb, input int inc_new,
                       input int ncyc);
        int   j;
        int   ph;
        logic sy;
        restart(32'h1000_0000, p, d);
        for (int n = 1; n <= ncyc; n++) begin
            if (nload > 0 && n == 6) begin
                cfg_load = 1'b1;
                f_word   = fa;
            end else if (nload > 1 && n == 7) begin
                cfg_load = 1'b1;
                f_word   = fb;
            end else begin
                cfg_load = 1'b0;
            end
            step();
            if (nload > 0) chk("busy", cfg_busy, 32'(n >= 6 && n < 16));
            if (n >= 3) begin
                j = n - 3;
                if (nload == 0 || j <= 16) begin
                    ph = (j * 1024 + p) % 16384;
                    sy = (j > 0) && ((j * 1024) % 16384 == 0);
                end else begin
                    ph = ((j - 16) * inc_new + p) % 16384;
                    sy = ((j - 16) * inc_new) % 16384 == 0;
                end
                check_wave(ph, d, sy);
            end
        end
        cfg_load = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        run      = 1'b0;
        cfg_load = 1'b0;
        f_word   = '0;
        p_word   = '0;
        duty     = '0;
`ifdef SWEEP_EN
        sweep_step = '0;
        f_stop     = '0;
`endif
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            chk("idle_sync", sync, 0);
            chk("idle_saw", dac_data2, 0);
            chk("idle_tri", dac_data1, 0);
            chk("idle_sq", dac_data3, 0);
            chk("idle_busy", cfg_busy, 0);
        end

        seq(14'd0, 14'd8192, 0, 32'h0, 32'h0, 0, 38);
        seq(14'd4096, 14'd8192, 0, 32'h0, 32'h0, 0, 22);
        seq(14'd0, 14'd0, 0, 32'h0, 32'h0, 0, 22);
        seq(14'd0, 14'd8192, 1, 32'h2000_0000, 32'h0, 2048, 42);
        seq(14'd0, 14'd8192, 2, 32'h0800_0000, 32'h0400_0000, 256, 40);

`ifdef SWEEP_EN
        begin
            int   k;
            int   prev_saw;
            logic prev_sync;
            int   exp_d [5];
            exp_d      = '{320, 384, 448, 512, 256};
            sweep_step = 32'h0100_0000;
            f_stop     = 32'h0800_0000;
            restart(32'h0400_0000, 14'd0, 14'd8192);
            k         = 0;
            prev_saw  = 0;
            prev_sync = 1'b0;
            for (int n = 0; n < 400 && k < 5; n++) begin
                step();
                if (prev_sync) begin
                    chk("sweep_step",
                        (int'(dac_data2) - prev_saw + 16384) % 16384,
                        exp_d[k]);
                    k++;
                end
                prev_saw  = int'(dac_data2);
                prev_sync = sync;
            end
            chk("sweep_wraps", k, 5);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
